regfile_scoreboard: RTL and testbench

Parametrised successor to the single-cycle integer register file, intended for the pipelined core.
- 2 combinational read ports and 1 clocked write port, with write-through bypass so decode sees the same-cycle writeback value.
- Optional hard-wired zero register.
- Per-register pending-write counters (scoreboard) for RAW hazard detection.
- Sits between decode (reads, issue) and writeback (WE3/A3/WD3).

---
 rtl/regfile_scoreboard.sv | 122 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W integer register file with write-through bypass,
// an optional hard-wired zero register and per-register pending-write counters
// that decode uses to detect RAW hazards against in-flight writebacks.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int PCNT_W   = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [AW-1:0]   A1,
   input  logic [AW-1:0]   A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   input  logic            WE3,
   input  logic [AW-1:0]   A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            ISSUE,
   input  logic [AW-1:0]   ISSUE_RD,
   output logic            ISSUE_READY,
   output logic            BUSY1,
   output logic            BUSY2
);

   localparam int                NREG    = 2**AW;
   localparam logic [PCNT_W-1:0] CNT_MAX = {PCNT_W{1'b1}};

   // Flattened views of per-register state, driven from the generate blocks.
   logic [XLEN-1:0]   reg_q [NREG];
   logic [PCNT_W-1:0] cnt_q [NREG];

   logic issue_is_zero;
   logic wb_hits_issue;

   assign issue_is_zero = (ZERO_REG != 0) && (ISSUE_RD == '0);
   assign wb_hits_issue = WE3 && (A3 == ISSUE_RD);

   // A writeback to the same register this cycle frees a slot, so a full
   // counter can still accept the issue without wrapping.
   assign ISSUE_READY = RST || issue_is_zero || wb_hits_issue
                        || (cnt_q[ISSUE_RD] != CNT_MAX);

   genvar gi;

   for (gi = 0; gi < NREG; gi++) begin : g_reg
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
         assign reg_q[gi] = '0;
         assign cnt_q[gi] = '0;
      end else begin : g_live
         logic [XLEN-1:0]   data_reg;
         logic [PCNT_W-1:0] cnt_reg;
         logic              wr_hit;
         logic              inc;
         logic              dec;

         assign wr_hit = WE3 && (A3 == AW'(gi));
         assign inc    = ISSUE && (ISSUE_RD == AW'(gi)) && ISSUE_READY;
         // Writes to an idle register are untracked: never count below zero.
         assign dec    = wr_hit && (cnt_reg != '0);

         // Register storage: written by the writeback port.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               data_reg <= '0;
            end else if (wr_hit) begin
               data_reg <= WD3;
            end
         end

         // Pending-write counter: issue increments, tracked writeback decrements.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               cnt_reg <= '0;
            end else if (inc && !dec) begin
               cnt_reg <= cnt_reg + 1'b1;
            end else if (dec && !inc) begin
               cnt_reg <= cnt_reg - 1'b1;
            end
         end

         assign reg_q[gi] = data_reg;
         assign cnt_q[gi] = cnt_reg;
      end
   end

   logic [AW-1:0] rd_addr [2];
   assign rd_addr[0] = A1;
   assign rd_addr[1] = A2;

   for (gi = 0; gi < 2; gi++) begin : g_port
      logic              is_zero;
      logic              wb_hit;
      logic [PCNT_W-1:0] cnt_after;
      logic [XLEN-1:0]   rd_data;
      logic              busy;

      assign is_zero = (ZERO_REG != 0) && (rd_addr[gi] == '0);
      assign wb_hit  = WE3 && (A3 == rd_addr[gi]);

      // Read mux: zero register and reset win, then same-cycle writeback bypass.
      always_comb begin
         rd_data = reg_q[rd_addr[gi]];
         if (RST || is_zero) begin
            rd_data = '0;
         end else if (wb_hit) begin
            rd_data = WD3;
         end
      end

      // Busy means still pending once this cycle's writeback has retired.
      assign cnt_after = cnt_q[rd_addr[gi]]
                         - PCNT_W'(wb_hit && (cnt_q[rd_addr[gi]] != '0));
      assign busy      = !RST && !is_zero && (cnt_after != '0);
   end

   assign RD1   = g_port[0].rd_data;
   assign RD2   = g_port[1].rd_data;
   assign BUSY1 = g_port[0].busy;
   assign BUSY2 = g_port[1].busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expected values into
// a queue and raises a sample event; a monitor pops and compares the outputs.
module tb_regfile_scoreboard;

   localparam int S_RD1    = 0;
   localparam int S_RD2    = 1;
   localparam int S_BUSY1  = 2;
   localparam int S_BUSY2  = 3;
   localparam int S_READY  = 4;
   localparam int S_BRD1   = 5;
   localparam int S_BRD2   = 6;
   localparam int S_BBUSY1 = 7;
   localparam int S_BBUSY2 = 8;
   localparam int S_BREADY = 9;

   typedef struct {
      int          sig;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;

   // Default instance: XLEN=32, AW=5, ZERO_REG=1, PCNT_W=2
   logic [4:0]  A1 = '0, A2 = '0, A3 = '0, ISSUE_RD = '0;
   logic [31:0] WD3 = '0;
   logic        WE3 = 1'b0, ISSUE = 1'b0;
   logic [31:0] RD1, RD2;
   logic        BUSY1, BUSY2, ISSUE_READY;

   // Wide instance: XLEN=64, AW=6, ZERO_REG=0
   logic [5:0]  b_a1 = '0, b_a2 = '0, b_a3 = '0, b_issue_rd = '0;
   logic [63:0] b_wd3 = '0;
   logic        b_we3 = 1'b0, b_issue = 1'b0;
   logic [63:0] b_rd1, b_rd2;
   logic        b_busy1, b_busy2, b_ready;

   always #5 CLK = ~CLK;

   regfile_scoreboard dut (
      .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .WE3(WE3), .A3(A3), .WD3(WD3), .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD),
      .ISSUE_READY(ISSUE_READY), .BUSY1(BUSY1), .BUSY2(BUSY2)
   );

   regfile_scoreboard #(.XLEN(64), .AW(6), .ZERO_REG(0), .PCNT_W(2)) dut_b (
      .CLK(CLK), .RST(RST), .A1(b_a1), .A2(b_a2), .RD1(b_rd1), .RD2(b_rd2),
      .WE3(b_we3), .A3(b_a3), .WD3(b_wd3), .ISSUE(b_issue), .ISSUE_RD(b_issue_rd),
      .ISSUE_READY(b_ready), .BUSY1(b_busy1), .BUSY2(b_busy2)
   );

   function automatic logic [63:0] read_sig(input int s);
      case (s)
         S_RD1:    return {32'd0, RD1};
         S_RD2:    return {32'd0, RD2};
         S_BUSY1:  return {63'd0, BUSY1};
         S_BUSY2:  return {63'd0, BUSY2};
         S_READY:  return {63'd0, ISSUE_READY};
         S_BRD1:   return b_rd1;
         S_BRD2:   return b_rd2;
         S_BBUSY1: return {63'd0, b_busy1};
         S_BBUSY2: return {63'd0, b_busy2};
         S_BREADY: return {63'd0, b_ready};
         default:  return 64'hx;
      endcase
   endfunction

   task automatic chk(input int sig, input logic [63:0] exp, input string name);
      exp_t e;
      e.sig  = sig;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic fire();
      ->sample_ev;
      #1;
   endtask

   task automatic nxt();
      @(negedge CLK);
   endtask

   // Monitor: on each sample request, drain the queue against live outputs.
   initial begin
      exp_t        e;
      logic [63:0] got;
      forever begin
         @(sample_ev);
         while (q.size() > 0) begin
            e   = q.pop_front();
            got = read_sig(e.sig);
            checks++;
            if (got !== e.exp) begin
               errors++;
               $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, got, e.exp, $time);
            end else begin
               $display("ok   %s: 0x%0h (t=%0t)", e.name, got, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      #1 RST = 1'b1;
      A1 = 5'd5;
      settle();
      checks++;
      if (RD1 !== 32'd0) begin
         errors++;
         $display("FAIL direct_reset_rd1: got 0x%0h, expected 0x0 (t=%0t)", RD1, $time);
      end else begin
         $display("ok   direct_reset_rd1: 0x%0h (t=%0t)", RD1, $time);
      end
      chk(S_RD1, 64'd0, "reset_rd1");
      chk(S_BUSY1, 64'd0, "reset_busy1");
      chk(S_READY, 64'd1, "reset_ready");
      chk(S_BRD1, 64'd0, "reset_b_rd1");
      fire();
      nxt();
      RST = 1'b0;

      // Write with same-cycle bypass, then stored read-back
      nxt();
      WE3 = 1; A3 = 5'd5; WD3 = 32'd42; A1 = 5'd5;
      settle();
      checks++;
      if (RD1 !== 32'd42) begin
         errors++;
         $display("FAIL direct_bypass_rd1: got 0x%0h, expected 0x2a (t=%0t)", RD1, $time);
      end else begin
         $display("ok   direct_bypass_rd1: 0x%0h (t=%0t)", RD1, $time);
      end
      chk(S_RD1, 64'd42, "bypass_rd1"); fire();
      nxt();
      WE3 = 0;
      settle(); chk(S_RD1, 64'd42, "stored_rd1"); fire();
      nxt(); WE3 = 1; A3 = 5'd5;  WD3 = 32'd77;
      nxt(); WE3 = 1; A3 = 5'd10; WD3 = 32'd100;
      nxt(); WE3 = 0; A1 = 5'd5; A2 = 5'd10;
      settle(); chk(S_RD1, 64'd77, "rd1_reg5"); chk(S_RD2, 64'd100, "rd2_reg10"); fire();
      nxt(); WE3 = 1; A3 = 5'd10; WD3 = 32'd55; A1 = 5'd10; A2 = 5'd10;
      settle(); chk(S_RD1, 64'd55, "dual_bypass_rd1"); chk(S_RD2, 64'd55, "dual_bypass_rd2"); fire();

      // Zero register
      nxt(); WE3 = 1; A3 = 5'd0; WD3 = 32'hDEADBEEF; A1 = 5'd0; A2 = 5'd0;
      settle(); chk(S_RD1, 64'd0, "zero_wr_rd1"); chk(S_RD2, 64'd0, "zero_wr_rd2"); fire();
      nxt(); WE3 = 0;
      settle(); chk(S_RD1, 64'd0, "zero_after_rd1"); chk(S_RD2, 64'd0, "zero_after_rd2"); fire();
      nxt(); ISSUE = 1; ISSUE_RD = 5'd0;
      settle(); chk(S_READY, 64'd1, "zero_issue_ready"); fire();
      nxt(); ISSUE = 0;
      settle(); chk(S_BUSY1, 64'd0, "zero_never_busy"); fire();

      // Scoreboard latency on reg7
      nxt(); A1 = 5'd7; ISSUE = 1; ISSUE_RD = 5'd7;
      settle(); chk(S_BUSY1, 64'd0, "busy7_issue_cycle"); fire();
      nxt(); ISSUE = 0;
      settle(); chk(S_BUSY1, 64'd1, "busy7_n1"); fire();
      nxt();
      settle(); chk(S_BUSY1, 64'd1, "busy7_n2"); fire();
      nxt(); WE3 = 1; A3 = 5'd7; WD3 = 32'h1234;
      settle(); chk(S_BUSY1, 64'd0, "busy7_wb_cycle"); chk(S_RD1, 64'h1234, "rd7_wb_bypass"); fire();
      nxt(); WE3 = 0;
      settle(); chk(S_BUSY1, 64'd0, "busy7_after"); chk(S_RD1, 64'h1234, "rd7_after"); fire();

      // Saturation on reg9
      A2 = 5'd9; ISSUE_RD = 5'd9;
      for (int i = 0; i < 3; i++) begin
         nxt(); ISSUE = 1;
         settle(); chk(S_READY, 64'd1, $sformatf("sat_ready_issue%0d", i)); fire();
      end
      nxt(); ISSUE = 1;
      settle(); chk(S_READY, 64'd0, "sat_ready_full"); chk(S_BUSY2, 64'd1, "sat_busy2_full"); fire();
      nxt(); WE3 = 1; A3 = 5'd9; WD3 = 32'd9; ISSUE = 1;
      settle(); chk(S_READY, 64'd1, "sat_ready_wb_frees"); chk(S_BUSY2, 64'd1, "sat_busy2_wb_issue"); fire();
      nxt(); WE3 = 0; ISSUE = 0;
      settle(); chk(S_READY, 64'd0, "sat_count_still_max"); fire();
      for (int i = 0; i < 3; i++) begin
         nxt(); WE3 = 1; A3 = 5'd9; WD3 = 32'(i);
         settle(); chk(S_BUSY2, (i < 2) ? 64'd1 : 64'd0, $sformatf("sat_drain_busy2_%0d", i)); fire();
      end
      nxt(); WE3 = 1; A3 = 5'd9; WD3 = 32'd99;
      settle(); chk(S_BUSY2, 64'd0, "untracked_wb_busy2"); fire();
      nxt(); WE3 = 0;
      settle(); chk(S_BUSY2, 64'd0, "no_underflow_busy2"); chk(S_READY, 64'd1, "no_underflow_ready");
      chk(S_RD2, 64'd99, "untracked_wb_data"); fire();

      // Write+issue same cycle, then asynchronous reset mid-operation
      nxt(); WE3 = 1; A3 = 5'd5; WD3 = 32'd42; ISSUE = 1; ISSUE_RD = 5'd5; A1 = 5'd5;
      settle(); chk(S_BUSY1, 64'd0, "wr_issue_same_busy1"); fire();
      nxt(); WE3 = 0;
      settle(); chk(S_BUSY1, 64'd1, "wr_issue_next_busy1"); chk(S_RD1, 64'd42, "wr_issue_rd1"); fire();
      nxt();
      nxt(); ISSUE = 0;
      settle(); chk(S_READY, 64'd0, "pre_reset_ready"); chk(S_BUSY1, 64'd1, "pre_reset_busy1"); fire();
      RST = 1'b1;
      settle();
      checks++;
      if (RD1 !== 32'd0) begin
         errors++;
         $display("FAIL direct_async_rd1: got 0x%0h, expected 0x0 (t=%0t)", RD1, $time);
      end else begin
         $display("ok   direct_async_rd1: 0x%0h (t=%0t)", RD1, $time);
      end
      checks++;
      if (BUSY1 !== 1'b0) begin
         errors++;
         $display("FAIL direct_async_busy1: got %0b, expected 0 (t=%0t)", BUSY1, $time);
      end else begin
         $display("ok   direct_async_busy1: %0b (t=%0t)", BUSY1, $time);
      end
      checks++;
      if (ISSUE_READY !== 1'b1) begin
         errors++;
         $display("FAIL direct_async_ready: got %0b, expected 1 (t=%0t)", ISSUE_READY, $time);
      end else begin
         $display("ok   direct_async_ready: %0b (t=%0t)", ISSUE_READY, $time);
      end
      chk(S_RD1, 64'd0, "async_reset_rd1"); chk(S_BUSY1, 64'd0, "async_reset_busy1");
      chk(S_READY, 64'd1, "async_reset_ready"); fire();
      nxt(); RST = 1'b0;
      settle(); chk(S_RD1, 64'd0, "post_reset_rd1"); chk(S_READY, 64'd1, "post_reset_ready"); fire();

      // Wide instance without zero register
      nxt(); b_we3 = 1; b_a3 = 6'd63; b_wd3 = 64'hFFFF_FFFF_FFFF_FFFF; b_a2 = 6'd63;
      settle(); chk(S_BRD2, 64'hFFFF_FFFF_FFFF_FFFF, "b_bypass_reg63"); fire();
      nxt(); b_a3 = 6'd0; b_wd3 = 64'd1; b_a1 = 6'd63;
      settle();
      checks++;
      if (b_rd1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL direct_b_stored_reg63: got 0x%0h (t=%0t)", b_rd1, $time);
      end else begin
         $display("ok   direct_b_stored_reg63: 0x%0h (t=%0t)", b_rd1, $time);
      end
      chk(S_BRD1, 64'hFFFF_FFFF_FFFF_FFFF, "b_stored_reg63"); fire();
      nxt(); b_we3 = 0; b_a1 = 6'd0; b_issue = 1; b_issue_rd = 6'd0;
      settle(); chk(S_BRD1, 64'd1, "b_reg0_writable"); chk(S_BBUSY1, 64'd0, "b_reg0_issue_cycle"); fire();
      nxt(); b_issue = 0;
      settle(); chk(S_BBUSY1, 64'd1, "b_reg0_busy"); chk(S_BREADY, 64'd1, "b_reg0_ready"); fire();
      nxt(); b_we3 = 1; b_a3 = 6'd0; b_wd3 = 64'd2;
      settle(); chk(S_BBUSY1, 64'd0, "b_reg0_wb_cycle"); chk(S_BRD1, 64'd2, "b_reg0_bypass"); fire();
      nxt(); b_we3 = 0;
      settle(); chk(S_BBUSY1, 64'd0, "b_reg0_idle"); chk(S_BBUSY2, 64'd0, "b_reg63_idle"); fire();

      #2;
      if (errors != 0) begin
         $display("FAIL summary: %0d checks, %0d errors", checks, errors);
      end else begin
         $display("PASS summary: %0d checks, %0d errors", checks, errors);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
